stage_mem: RTL and testbench
============================

STAGE_MEM -- requirements
Module: stage_mem

Interface
REQ-001 SHALL have one clock and one reset: reset is asynchronous and active-high (reset=1 asserts, effective without a clock edge).
REQ-002 clock  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  asynchronous active-high reset.
REQ-004 ex_register_write_enable / ex_register_write_address / ex_register_write_data  in  1/5/32  EX-stage writeback request.
REQ-005 ex_memory_operation  in  4  MEM_NONE, MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW, MEM_SB, MEM_SH, MEM_SW.
REQ-006 ex_memory_address / ex_memory_write_data  in  32/32  effective byte address; store source data.
REQ-007 mem_register_write_enable / mem_register_write_address / mem_register_write_data  out  1/5/32  to MEM/WB latch.
REQ-008 mem_address_error  out  1  misaligned access this cycle.
REQ-009 stall_request  out  1  hold pipeline, MEM stage busy.
REQ-010 bus_request / bus_write_enable  out  1/1  memory access valid; 1=store.
REQ-011 bus_address / bus_select / bus_write_data  out  32/4/32  word address (bits 1:0 = 0); byte lanes, bit3 = bits 31:24; lane-aligned store data.
REQ-012 bus_read_data / bus_ack  in  32/1  read word; access completes on the edge where ack=1.

Function
REQ-013 SHALL implement FSM IDLE, BUSY, DONE; big-endian byte order (offset 0 = bits 31:24).
REQ-014 MEM_NONE in IDLE: mem_register_write_* = ex_register_write_* combinationally, stall_request=0, no bus_request.
REQ-015 Aligned memory op in IDLE: bus_request=1, stall_request=1 same cycle; bus_ack=1 at edge -> DONE, else -> BUSY.
REQ-016 BUSY: bus_* held stable from registered copies, stall_request=1, mem_register_write_enable=0; bus_ack=1 at edge -> DONE.
REQ-017 On the completing edge, bus_read_data SHALL be captured into an internal register.
REQ-018 DONE: bus_request=0, stall_request=0, writeback from captured data (loads) or enable=0 (stores); unconditional -> IDLE.
REQ-019 Loads: LB/LH sign-extend, LBU/LHU zero-extend the lane chosen by address[1:0]; LW whole word.
REQ-020 SB: bus_select = 4'b1000 >> address[1:0], write data byte replicated to all lanes; SH: 1100 (offset 0) or 0011 (offset 2), halfword replicated; SW: 1111.
REQ-021 Loads: bus_select identical to the equivalent store; bus_write_enable=0.
REQ-022 Misalignment (LH/LHU/SH address[0]=1; LW/SW address[1:0]!=0): mem_address_error=1, no bus_request, stall_request=0, mem_register_write_enable=0, FSM stays IDLE.
REQ-023 Stores SHALL force mem_register_write_enable=0 regardless of ex input.
REQ-024 mem_address_error SHALL be 0 in BUSY and DONE.

Reset
REQ-025 Reset SHALL force IDLE, captured data 0, held bus registers 0; bus_request and stall_request drop immediately, including mid-BUSY (access abandoned, late bus_ack ignored).
REQ-026 After reset release, first edge evaluates inputs as IDLE.

Structure
REQ-027 Memory operation encodings and the RESET_ENABLE (=1) constant SHALL live in the shared CPU defines file.
REQ-028 Lane select, store replication and load extension SHALL be one combinational sub-module, load_store_align.
REQ-029 All registers SHALL be in stage_mem; no latches inferred.

Verification
REQ-030 LW 0x100, bus_ack in request cycle, data 0x12345678 -> stall 1 cycle, DONE writes 0x12345678, next cycle IDLE.
REQ-031 LB 0x103, ack after 3 BUSY cycles, data 0x000000F0 -> stall 4 cycles, write 0xFFFFFFF0; LBU -> 0x000000F0.
REQ-032 SH 0x202 data 0x0000BEEF -> bus_select 0011, bus_write_data 0xBEEFBEEF, bus_write_enable 1, register write 0.
REQ-033 LW 0x101 -> mem_address_error 1, bus_request 0, stall 0, write enable 0.
REQ-034 Reset asserted mid-BUSY -> bus_request/stall 0 immediately; ack one cycle after release ignored, no writeback.
REQ-035 Non-memory op r5 <= 0xCAFEBABE -> same-cycle pass-through, stall 0.

Source files
------------

// File: rtl/stage_mem_pkg.sv
// Shared CPU defines for the memory stage: operation encodings, reset level, FSM states.
package stage_mem_pkg;

  localparam logic RESET_ENABLE = 1'b1;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    MEM_LB   = 4'd1,
    MEM_LBU  = 4'd2,
    MEM_LH   = 4'd3,
    MEM_LHU  = 4'd4,
    MEM_LW   = 4'd5,
    MEM_SB   = 4'd6,
    MEM_SH   = 4'd7,
    MEM_SW   = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } mem_state_e;

endpackage

// File: rtl/stage_mem_align.sv
// Big-endian byte-lane selection, store replication, load extension and alignment check.
module load_store_align
  import stage_mem_pkg::*;
(
  input  logic [3:0]  i_op,
  input  logic [1:0]  i_offset,
  input  logic [31:0] i_store_data,
  input  logic [31:0] i_load_word,
  output logic        o_is_load,
  output logic        o_is_store,
  output logic        o_misaligned,
  output logic [3:0]  o_select,
  output logic [31:0] o_store_data,
  output logic [31:0] o_load_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [3:0]  w_byte_sel;
  logic [3:0]  w_half_sel;

  // Offset 0 addresses the most significant lane.
  assign w_byte_sel = 4'b1000 >> i_offset;
  assign w_half_sel = i_offset[1] ? 4'b0011 : 4'b1100;
  assign w_half     = i_offset[1] ? i_load_word[15:0] : i_load_word[31:16];

  always_comb begin
    w_byte = i_load_word[31:24];
    case (i_offset)
      2'd1:    w_byte = i_load_word[23:16];
      2'd2:    w_byte = i_load_word[15:8];
      2'd3:    w_byte = i_load_word[7:0];
      default: w_byte = i_load_word[31:24];
    endcase
  end

  always_comb begin
    o_is_load    = 1'b0;
    o_is_store   = 1'b0;
    o_misaligned = 1'b0;
    o_select     = 4'b0000;
    o_store_data = i_store_data;
    o_load_data  = i_load_word;
    case (i_op)
      MEM_LB:  begin o_is_load = 1'b1; o_select = w_byte_sel; o_load_data = {{24{w_byte[7]}}, w_byte}; end
      MEM_LBU: begin o_is_load = 1'b1; o_select = w_byte_sel; o_load_data = {24'd0, w_byte}; end
      MEM_LH:  begin
        o_is_load = 1'b1; o_select = w_half_sel; o_misaligned = i_offset[0];
        o_load_data = {{16{w_half[15]}}, w_half};
      end
      MEM_LHU: begin
        o_is_load = 1'b1; o_select = w_half_sel; o_misaligned = i_offset[0];
        o_load_data = {16'd0, w_half};
      end
      MEM_LW:  begin o_is_load = 1'b1; o_select = 4'b1111; o_misaligned = (i_offset != 2'd0); end
      MEM_SB:  begin o_is_store = 1'b1; o_select = w_byte_sel; o_store_data = {4{i_store_data[7:0]}}; end
      MEM_SH:  begin
        o_is_store = 1'b1; o_select = w_half_sel; o_misaligned = i_offset[0];
        o_store_data = {2{i_store_data[15:0]}};
      end
      MEM_SW:  begin o_is_store = 1'b1; o_select = 4'b1111; o_misaligned = (i_offset != 2'd0); end
      default: ;
    endcase
  end

endmodule

// File: rtl/stage_mem.sv
// MEM pipeline stage: issues one bus access per memory op, stalls until ack, then writes back.
module stage_mem
  import stage_mem_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        ex_register_write_enable,
  input  logic [4:0]  ex_register_write_address,
  input  logic [31:0] ex_register_write_data,
  input  logic [3:0]  ex_memory_operation,
  input  logic [31:0] ex_memory_address,
  input  logic [31:0] ex_memory_write_data,
  output logic        mem_register_write_enable,
  output logic [4:0]  mem_register_write_address,
  output logic [31:0] mem_register_write_data,
  output logic        mem_address_error,
  output logic        stall_request,
  output logic        bus_request,
  output logic        bus_write_enable,
  output logic [31:0] bus_address,
  output logic [3:0]  bus_select,
  output logic [31:0] bus_write_data,
  input  logic [31:0] bus_read_data,
  input  logic        bus_ack
);

  mem_state_e  r_state, w_next_state;
  logic [3:0]  r_op;
  logic [31:0] r_addr, r_store_data, r_read_data;
  logic        r_wr_en;
  logic [4:0]  r_wr_addr;

  logic        w_idle, w_reset_active;
  logic [3:0]  w_op;
  logic [31:0] w_addr, w_store_src, w_store_lanes, w_load_data;
  logic [3:0]  w_select;
  logic        w_is_load, w_is_store, w_misaligned, w_accept, w_complete;

  // Outside IDLE the bus is driven from the copies latched when the access was accepted.
  assign w_idle         = (r_state == ST_IDLE);
  assign w_reset_active = (reset == RESET_ENABLE);
  assign w_op           = w_idle ? ex_memory_operation  : r_op;
  assign w_addr         = w_idle ? ex_memory_address    : r_addr;
  assign w_store_src    = w_idle ? ex_memory_write_data : r_store_data;

  load_store_align u_align (
    .i_op         (w_op),
    .i_offset     (w_addr[1:0]),
    .i_store_data (w_store_src),
    .i_load_word  (r_read_data),
    .o_is_load    (w_is_load),
    .o_is_store   (w_is_store),
    .o_misaligned (w_misaligned),
    .o_select     (w_select),
    .o_store_data (w_store_lanes),
    .o_load_data  (w_load_data)
  );

  assign w_accept   = w_idle && (w_is_load || w_is_store) && !w_misaligned;
  assign w_complete = (w_accept || (r_state == ST_BUSY)) && bus_ack;

  assign bus_address      = {w_addr[31:2], 2'b00};
  assign bus_select       = w_select;
  assign bus_write_data   = w_store_lanes;
  assign bus_write_enable = bus_request && w_is_store;

  always_ff @(posedge clock or posedge reset) begin
    if (reset == RESET_ENABLE) r_state <= ST_IDLE;
    else                       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state               = r_state;
    bus_request                = 1'b0;
    stall_request              = 1'b0;
    mem_address_error          = 1'b0;
    mem_register_write_enable  = 1'b0;
    mem_register_write_address = ex_register_write_address;
    mem_register_write_data    = ex_register_write_data;
    case (r_state)
      ST_IDLE: begin
        if (!(w_is_load || w_is_store)) begin
          mem_register_write_enable = ex_register_write_enable;
        end else if (w_misaligned) begin
          mem_address_error = 1'b1;
        end else begin
          bus_request   = 1'b1;
          stall_request = 1'b1;
          w_next_state  = bus_ack ? ST_DONE : ST_BUSY;
        end
      end
      ST_BUSY: begin
        bus_request                = 1'b1;
        stall_request              = 1'b1;
        mem_register_write_address = r_wr_addr;
        if (bus_ack) w_next_state  = ST_DONE;
      end
      ST_DONE: begin
        mem_register_write_enable  = r_wr_en && w_is_load;
        mem_register_write_address = r_wr_addr;
        mem_register_write_data    = w_load_data;
        w_next_state               = ST_IDLE;
      end
      default: w_next_state = ST_IDLE;
    endcase
    // Reset abandons any access at once, before the state register settles.
    if (w_reset_active) begin
      bus_request   = 1'b0;
      stall_request = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset == RESET_ENABLE) begin
      r_op         <= 4'd0;
      r_addr       <= 32'd0;
      r_store_data <= 32'd0;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= 5'd0;
      r_read_data  <= 32'd0;
    end else begin
      if (w_accept) begin
        r_op         <= ex_memory_operation;
        r_addr       <= ex_memory_address;
        r_store_data <= ex_memory_write_data;
        r_wr_en      <= ex_register_write_enable;
        r_wr_addr    <= ex_register_write_address;
      end
      if (w_complete) r_read_data <= bus_read_data;
    end
  end

endmodule

// File: tb/tb_stage_mem.sv
// Directed and randomized bench for stage_mem against a byte-lane arithmetic reference model.
module tb_stage_mem;
  import stage_mem_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        ex_register_write_enable;
  logic [4:0]  ex_register_write_address;
  logic [31:0] ex_register_write_data;
  logic [3:0]  ex_memory_operation;
  logic [31:0] ex_memory_address;
  logic [31:0] ex_memory_write_data;
  logic        mem_register_write_enable;
  logic [4:0]  mem_register_write_address;
  logic [31:0] mem_register_write_data;
  logic        mem_address_error;
  logic        stall_request;
  logic        bus_request;
  logic        bus_write_enable;
  logic [31:0] bus_address;
  logic [3:0]  bus_select;
  logic [31:0] bus_write_data;
  logic [31:0] bus_read_data;
  logic        bus_ack;

  int tests = 0;
  int fails = 0;

  always #5 clock = ~clock;

  stage_mem dut (
    .clock                      (clock),
    .reset                      (reset),
    .ex_register_write_enable   (ex_register_write_enable),
    .ex_register_write_address  (ex_register_write_address),
    .ex_register_write_data     (ex_register_write_data),
    .ex_memory_operation        (ex_memory_operation),
    .ex_memory_address          (ex_memory_address),
    .ex_memory_write_data       (ex_memory_write_data),
    .mem_register_write_enable  (mem_register_write_enable),
    .mem_register_write_address (mem_register_write_address),
    .mem_register_write_data    (mem_register_write_data),
    .mem_address_error          (mem_address_error),
    .stall_request              (stall_request),
    .bus_request                (bus_request),
    .bus_write_enable           (bus_write_enable),
    .bus_address                (bus_address),
    .bus_select                 (bus_select),
    .bus_write_data             (bus_write_data),
    .bus_read_data              (bus_read_data),
    .bus_ack                    (bus_ack)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: access size in bytes, big-endian lane arithmetic.
  function automatic int op_size(input int op);
    case (op)
      1, 2, 6: return 1;
      3, 4, 7: return 2;
      5, 8:    return 4;
      default: return 0;
    endcase
  endfunction

  function automatic bit op_load(input int op);
    return (op >= 1 && op <= 5);
  endfunction

  function automatic bit op_store(input int op);
    return (op >= 6 && op <= 8);
  endfunction

  function automatic bit op_misaligned(input int op, input logic [31:0] addr);
    int sz = op_size(op);
    return (sz != 0) && ((addr % sz) != 0);
  endfunction

  function automatic logic [3:0] exp_select(input int op, input logic [31:0] addr);
    int sz  = op_size(op);
    int off = int'(addr % 4);
    int m   = ((1 << sz) - 1) << (4 - sz - off);
    return m[3:0];
  endfunction

  function automatic logic [31:0] exp_store(input int op, input logic [31:0] d);
    longint v;
    case (op_size(op))
      1:       v = longint'(d % 256) * 64'h01010101;
      2:       v = longint'(d % 65536) * 64'h00010001;
      default: v = longint'(d);
    endcase
    return v[31:0];
  endfunction

  function automatic logic [31:0] exp_load(input int op, input logic [31:0] addr, input logic [31:0] w);
    int     sz   = op_size(op);
    int     off  = int'(addr % 4);
    longint span = longint'(1) << (8 * sz);
    longint v    = (longint'(w) >> (8 * (4 - sz - off))) % span;
    if ((op == 1 || op == 3) && v >= span / 2) v = v - span;
    return v[31:0];
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One instruction through the stage; lat = number of BUSY cycles before ack.
  task automatic do_op(input string nm, input int op, input logic [31:0] addr, input logic [31:0] sdata,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input int lat, input logic [31:0] rdata);
    ex_memory_operation       = op[3:0];
    ex_memory_address         = addr;
    ex_memory_write_data      = sdata;
    ex_register_write_enable  = we;
    ex_register_write_address = wa;
    ex_register_write_data    = wd;
    bus_ack                   = (lat == 0);
    bus_read_data             = (lat == 0) ? rdata : $urandom;
    @(negedge clock);
    if (!op_load(op) && !op_store(op)) begin
      chk({nm, ".pass_we"}, mem_register_write_enable, we);
      chk({nm, ".pass_wa"}, mem_register_write_address, wa);
      chk({nm, ".pass_wd"}, mem_register_write_data, wd);
      chk({nm, ".pass_stall"}, stall_request, 0);
      chk({nm, ".pass_breq"}, bus_request, 0);
      step();
      return;
    end
    if (op_misaligned(op, addr)) begin
      chk({nm, ".mis_err"}, mem_address_error, 1);
      chk({nm, ".mis_breq"}, bus_request, 0);
      chk({nm, ".mis_stall"}, stall_request, 0);
      chk({nm, ".mis_we"}, mem_register_write_enable, 0);
      step();
      return;
    end
    for (int k = 0; k <= lat; k++) begin
      if (k > 0) begin
        ex_memory_address    = $urandom;
        ex_memory_write_data = $urandom;
        bus_ack              = (k == lat);
        bus_read_data        = (k == lat) ? rdata : $urandom;
        @(negedge clock);
      end
      chk({nm, ".req"}, bus_request, 1);
      chk({nm, ".stall"}, stall_request, 1);
      chk({nm, ".err"}, mem_address_error, 0);
      chk({nm, ".bwe"}, bus_write_enable, op_store(op));
      chk({nm, ".baddr"}, bus_address, addr & 32'hFFFF_FFFC);
      chk({nm, ".bsel"}, bus_select, exp_select(op, addr));
      if (op_store(op)) chk({nm, ".bwdata"}, bus_write_data, exp_store(op, sdata));
      chk({nm, ".busy_we"}, mem_register_write_enable, 0);
      step();
    end
    ex_memory_address    = addr;
    ex_memory_write_data = sdata;
    bus_ack              = 1'b0;
    bus_read_data        = $urandom;
    @(negedge clock);
    chk({nm, ".done_req"}, bus_request, 0);
    chk({nm, ".done_stall"}, stall_request, 0);
    chk({nm, ".done_err"}, mem_address_error, 0);
    chk({nm, ".done_we"}, mem_register_write_enable, op_load(op) && we);
    if (op_load(op) && we) begin
      chk({nm, ".done_wa"}, mem_register_write_address, wa);
      chk({nm, ".done_wd"}, mem_register_write_data, exp_load(op, addr, rdata));
    end
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    ex_register_write_enable  = 1'b0;
    ex_register_write_address = 5'd0;
    ex_register_write_data    = 32'd0;
    ex_memory_operation       = MEM_NONE;
    ex_memory_address         = 32'd0;
    ex_memory_write_data      = 32'd0;
    bus_read_data             = 32'd0;
    bus_ack                   = 1'b0;
    #1;
    chk("rst.breq", bus_request, 0);
    chk("rst.stall", stall_request, 0);
    chk("rst.err", mem_address_error, 0);
    step();
    step();
    reset = 1'b0;

    do_op("lw_fast", MEM_LW, 32'h100, 32'h0, 1'b1, 5'd3, 32'h0, 0, 32'h12345678);
    do_op("idle_after", MEM_NONE, 32'h0, 32'h0, 1'b1, 5'd4, 32'h11112222, 0, 32'h0);
    do_op("lb_slow", MEM_LB, 32'h103, 32'h0, 1'b1, 5'd7, 32'h0, 3, 32'h000000F0);
    do_op("lbu_slow", MEM_LBU, 32'h103, 32'h0, 1'b1, 5'd8, 32'h0, 3, 32'h000000F0);
    do_op("sh_202", MEM_SH, 32'h202, 32'h0000BEEF, 1'b1, 5'd9, 32'h0, 1, 32'h0);
    do_op("lw_mis", MEM_LW, 32'h101, 32'h0, 1'b1, 5'd2, 32'h0, 0, 32'h0);
    do_op("nonmem", MEM_NONE, 32'h0, 32'h0, 1'b1, 5'd5, 32'hCAFEBABE, 0, 32'h0);
    do_op("lh_neg", MEM_LH, 32'h402, 32'h0, 1'b1, 5'd10, 32'h0, 2, 32'h1234_8001);
    do_op("sb_1", MEM_SB, 32'h501, 32'hA5A5_A53C, 1'b1, 5'd11, 32'h0, 0, 32'h0);

    // Reset during BUSY: outputs drop without a clock edge, and a late ack is ignored.
    ex_memory_operation       = MEM_LW;
    ex_memory_address         = 32'h300;
    ex_register_write_enable  = 1'b1;
    ex_register_write_address = 5'd12;
    bus_ack                   = 1'b0;
    step();
    @(negedge clock);
    chk("rstbusy.req_before", bus_request, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("rstbusy.req", bus_request, 0);
    chk("rstbusy.stall", stall_request, 0);
    step();
    reset                    = 1'b0;
    ex_memory_operation      = MEM_NONE;
    ex_register_write_enable = 1'b0;
    step();
    bus_ack       = 1'b1;
    bus_read_data = 32'hDEAD_BEEF;
    @(negedge clock);
    chk("lateack.stall", stall_request, 0);
    chk("lateack.req", bus_request, 0);
    chk("lateack.we", mem_register_write_enable, 0);
    step();
    bus_ack = 1'b0;
    @(negedge clock);
    chk("lateack.we2", mem_register_write_enable, 0);
    chk("lateack.stall2", stall_request, 0);
    step();

    for (int i = 0; i < 60; i++) begin
      int          rop;
      logic [31:0] raddr;
      rop   = int'($urandom_range(0, 8));
      raddr = $urandom;
      if ($urandom_range(0, 3) != 0) raddr = raddr & ~(32'(op_size(rop) - 1) & 32'h3);
      do_op("rand", rop, raddr, $urandom, 1'($urandom), 5'($urandom), $urandom,
            int'($urandom_range(0, 3)), $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
